pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
//  Pipelined successor to the combinational MIPS decoder: decodes ID-stage op/funct, carries control through EX/MEM/WB registers.
//  Adds load-use hazard detection, EX/MEM and MEM/WB forwarding selects, flush/freeze handling, jump support and illegal-op detection.
//  Sits beside the datapath stage registers; drives all stage control and the IF/ID hold signal.
// PARAMETERS
//  REG_AW   5   register-address width
//  ALU_CW   4   ALU control width (team encoding, see ctrl_pkg)
//  JUMP_EN  1   1: decode j/jal/jr; 0: they are illegal
//  LINK_REG 31  destination register written by jal
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous reset, active low
//  id_valid     in   1        ID stage holds a live instruction
//  id_op        in   6        opcode
//  id_funct     in   6        funct field
//  id_rs        in   REG_AW   source A
//  id_rt        in   REG_AW   source B / I-type destination
//  id_rd        in   REG_AW   R-type destination
//  ex_flush     in   1        taken branch/jump resolved in EX: kill the ID instruction
//  mem_busy     in   1        data memory busy: freeze every stage register
//  hazard_stall out  1        hold PC and IF/ID (combinational)
//  illegal_op   out  1        registered 1-cycle pulse: unsupported opcode/funct in a live ID instruction
//  ex_ctrl      out  CTRL_W   EX-stage control bundle
//  ex_dst       out  REG_AW   EX-stage destination
//  mem_ctrl     out  CTRL_W   MEM-stage control bundle
//  mem_dst      out  REG_AW   MEM-stage destination
//  wb_ctrl      out  CTRL_W   WB-stage control bundle
//  wb_dst       out  REG_AW   WB-stage destination
//  fwd_a        out  2        EX operand A: 00 regfile, 10 EX/MEM, 01 MEM/WB
//  fwd_b        out  2        EX operand B, same encoding
// BEHAVIOUR
//  - Bundle fields: reg_write, mem_to_reg, mem_write, branch, jump, jump_reg, link, alu_ctrl, alu_src, alu_src_shamt.
//  - Decode: add/addu/addi/addiu/sub/subu/and/andi/or/ori/xor/xori/nor/sll/sllv/srl/srlv/sra/srav/slt/beq/bne/lw/sw (+ j/jal/jr if JUMP_EN).
//  - ALU codes: add 0010, sub 0110, and 0000, or 0001, xor 0011, nor 1100, sll 0100, srl 0101, sra 1000, slt 0111, beq 1001, bne 1010.
//  - Destination: R-type id_rd, I-type/lw id_rt, jal LINK_REG; no-write instructions 0.
//  - Bubble = all-zero bundle, dst 0. Reset: every stage bundle and dst 0, illegal_op 0, fwd_a/fwd_b 00.
//  - Latency: live ID decoded in cycle n appears on ex_* after edge n, mem_* after n+1, wb_* after n+2.
//  - Load-use: hazard_stall=1 when id_valid, ex.mem_to_reg, ex_dst!=0, and ex_dst==id_rs or (ex_dst==id_rt and instr reads rt); EX gets bubble.
//  - Priority each edge: rst_n > mem_busy (all stages hold, hazard_stall still computed, illegal_op 0) > ex_flush > load-use > normal.
//  - ex_flush: EX gets bubble; hazard_stall forced 0 same cycle; MEM/WB advance normally.
//  - Illegal/unsupported instruction in live ID: treated as bubble, illegal_op pulses next cycle unless flushed or stalled.
//  - Forward (comb., from registered EX-stage rs/rt): EX/MEM wins if mem.reg_write, mem_dst!=0, match; else MEM/WB if wb.reg_write, wb_dst!=0, match; register 0 never forwarded.
//  - id_valid=0: EX receives bubble, no stall, no illegal.
//  - Reset mid-operation: all in-flight control discarded immediately (async); first live instruction after release decodes normally.
// STRUCTURE
//  - ctrl_pkg (include file): ALU code constants, opcode/funct constants, bundle field offsets, CTRL_W, BUBBLE.
//  - One sub-module: ctrl_decode (pure combinational op/funct -> bundle, dst select, illegal, reads_rt).
//  - Top holds three stage registers, hazard and forwarding logic.
// TESTING
//  - Reset then idle: every output 0 for 10 cycles.
//  - add $3,$1,$2: ex_ctrl alu=0010 reg_write=1 one edge later; wb_dst=3 two edges after that.
//  - lw $5,0($1) then add $6,$5,$2: hazard_stall=1 for 1 cycle, EX bubble, then fwd_a=01 for the add.
//  - Load-use pair with ex_flush=1 on the stall cycle: hazard_stall=0, EX bubble, no fwd.
//  - mem_busy=1 for 3 cycles mid-stream: ex/mem/wb outputs unchanged, then resume in order.
//  - op=0x3F: illegal_op pulse, EX bubble; jal (JUMP_EN=1): wb_dst=31, link=1.

Source files
------------

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared control definitions for the pipelined MIPS control unit:
// ALU codes, opcode/funct values and the per-stage control bundle.
package pipe_ctrl_unit_pkg;

    localparam int unsigned ALU_CW = 4;
    localparam int unsigned OPF_W  = 6;

    localparam logic [ALU_CW-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CW-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CW-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CW-1:0] ALU_XOR = 4'b0011;
    localparam logic [ALU_CW-1:0] ALU_SLL = 4'b0100;
    localparam logic [ALU_CW-1:0] ALU_SRL = 4'b0101;
    localparam logic [ALU_CW-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CW-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CW-1:0] ALU_SRA = 4'b1000;
    localparam logic [ALU_CW-1:0] ALU_BEQ = 4'b1001;
    localparam logic [ALU_CW-1:0] ALU_BNE = 4'b1010;
    localparam logic [ALU_CW-1:0] ALU_NOR = 4'b1100;

    localparam logic [OPF_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPF_W-1:0] OP_J     = 6'h02;
    localparam logic [OPF_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPF_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPF_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPF_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPF_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPF_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPF_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPF_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPF_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPF_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OPF_W-1:0] F_SLL  = 6'h00;
    localparam logic [OPF_W-1:0] F_SRL  = 6'h02;
    localparam logic [OPF_W-1:0] F_SRA  = 6'h03;
    localparam logic [OPF_W-1:0] F_SLLV = 6'h04;
    localparam logic [OPF_W-1:0] F_SRLV = 6'h06;
    localparam logic [OPF_W-1:0] F_SRAV = 6'h07;
    localparam logic [OPF_W-1:0] F_JR   = 6'h08;
    localparam logic [OPF_W-1:0] F_ADD  = 6'h20;
    localparam logic [OPF_W-1:0] F_ADDU = 6'h21;
    localparam logic [OPF_W-1:0] F_SUB  = 6'h22;
    localparam logic [OPF_W-1:0] F_SUBU = 6'h23;
    localparam logic [OPF_W-1:0] F_AND  = 6'h24;
    localparam logic [OPF_W-1:0] F_OR   = 6'h25;
    localparam logic [OPF_W-1:0] F_XOR  = 6'h26;
    localparam logic [OPF_W-1:0] F_NOR  = 6'h27;
    localparam logic [OPF_W-1:0] F_SLT  = 6'h2A;

    // Field order fixes the bit offsets of the exported control vectors (reg_write is the MSB).
    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic              jump_reg;
        logic              link;
        logic [ALU_CW-1:0] alu_ctrl;
        logic              alu_src;
        logic              alu_src_shamt;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);
    localparam ctrl_t       BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage decoder: op/funct to control bundle, destination
// register, illegal flag and whether rt is read as a source.
module pipe_ctrl_unit_decode
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned JUMP_EN  = 1,
    parameter int unsigned LINK_REG = 31
) (
    input  logic [OPF_W-1:0]  op_i,
    input  logic [OPF_W-1:0]  funct_i,
    input  logic [REG_AW-1:0] rt_i,
    input  logic [REG_AW-1:0] rd_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [REG_AW-1:0] dst_o,
    output logic              illegal_o,
    output logic              reads_rt_o
);

    ctrl_t             c;
    logic [REG_AW-1:0] dst;
    logic              ill;
    logic              rrt;

    always_comb begin
        c   = BUBBLE;
        dst = '0;
        ill = 1'b0;
        rrt = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                dst         = rd_i;
                rrt         = 1'b1;
                case (funct_i)
                    F_ADD, F_ADDU: c.alu_ctrl = ALU_ADD;
                    F_SUB, F_SUBU: c.alu_ctrl = ALU_SUB;
                    F_AND:         c.alu_ctrl = ALU_AND;
                    F_OR:          c.alu_ctrl = ALU_OR;
                    F_XOR:         c.alu_ctrl = ALU_XOR;
                    F_NOR:         c.alu_ctrl = ALU_NOR;
                    F_SLT:         c.alu_ctrl = ALU_SLT;
                    F_SLLV:        c.alu_ctrl = ALU_SLL;
                    F_SRLV:        c.alu_ctrl = ALU_SRL;
                    F_SRAV:        c.alu_ctrl = ALU_SRA;
                    F_SLL: begin c.alu_ctrl = ALU_SLL; c.alu_src_shamt = 1'b1; end
                    F_SRL: begin c.alu_ctrl = ALU_SRL; c.alu_src_shamt = 1'b1; end
                    F_SRA: begin c.alu_ctrl = ALU_SRA; c.alu_src_shamt = 1'b1; end
                    F_JR: begin
                        c.reg_write = 1'b0;
                        c.jump_reg  = 1'b1;
                        dst         = '0;
                        rrt         = 1'b0;
                        ill         = (JUMP_EN == 0);
                    end
                    default: ill = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                dst         = rt_i;
                case (op_i)
                    OP_ANDI: c.alu_ctrl = ALU_AND;
                    OP_ORI:  c.alu_ctrl = ALU_OR;
                    OP_XORI: c.alu_ctrl = ALU_XOR;
                    default: c.alu_ctrl = ALU_ADD;
                endcase
                c.mem_to_reg = (op_i == OP_LW);
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_ctrl  = ALU_ADD;
                rrt         = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                c.branch   = 1'b1;
                c.alu_ctrl = (op_i == OP_BEQ) ? ALU_BEQ : ALU_BNE;
                rrt        = 1'b1;
            end
            OP_J: begin
                c.jump = 1'b1;
                ill    = (JUMP_EN == 0);
            end
            OP_JAL: begin
                c.jump      = 1'b1;
                c.link      = 1'b1;
                c.reg_write = 1'b1;
                dst         = REG_AW'(LINK_REG);
                ill         = (JUMP_EN == 0);
            end
            default: ill = 1'b1;
        endcase
        // Unsupported encodings collapse to a bubble so nothing downstream acts on them.
        if (ill) begin
            c   = BUBBLE;
            dst = '0;
            rrt = 1'b0;
        end
    end

    assign ctrl_o     = c;
    assign dst_o      = dst;
    assign illegal_o  = ill;
    assign reads_rt_o = rrt;

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes ID, carries control through EX/MEM/WB,
// detects load-use hazards, selects forwarding and flags illegal opcodes.
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned JUMP_EN  = 1,
    parameter int unsigned LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid_i,
    input  logic [OPF_W-1:0]  id_op_i,
    input  logic [OPF_W-1:0]  id_funct_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              ex_flush_i,
    input  logic              mem_busy_i,
    output logic              hazard_stall_o,
    output logic              illegal_op_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic [REG_AW-1:0] ex_dst_o,
    output logic [CTRL_W-1:0] mem_ctrl_o,
    output logic [REG_AW-1:0] mem_dst_o,
    output logic [CTRL_W-1:0] wb_ctrl_o,
    output logic [REG_AW-1:0] wb_dst_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
);

    logic [CTRL_W-1:0] dec_ctrl;
    logic [REG_AW-1:0] dec_dst;
    logic              dec_illegal;
    logic              dec_reads_rt;

    ctrl_t             ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
    logic [REG_AW-1:0] ex_dst_q, ex_dst_d, mem_dst_q, mem_dst_d, wb_dst_q, wb_dst_d;
    logic [REG_AW-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
    logic              illegal_q, illegal_d;
    logic              load_use_c;

    pipe_ctrl_unit_decode #(
        .REG_AW   (REG_AW),
        .JUMP_EN  (JUMP_EN),
        .LINK_REG (LINK_REG)
    ) u_decode (
        .op_i       (id_op_i),
        .funct_i    (id_funct_i),
        .rt_i       (id_rt_i),
        .rd_i       (id_rd_i),
        .ctrl_o     (dec_ctrl),
        .dst_o      (dec_dst),
        .illegal_o  (dec_illegal),
        .reads_rt_o (dec_reads_rt)
    );

    // A load in EX whose destination the ID instruction consumes must wait one cycle.
    assign load_use_c = id_valid_i && ex_ctrl_q.mem_to_reg && (ex_dst_q != '0) &&
                        ((ex_dst_q == id_rs_i) || (dec_reads_rt && (ex_dst_q == id_rt_i)));
    assign hazard_stall_o = load_use_c && !ex_flush_i;

    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        ex_dst_d   = ex_dst_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        mem_ctrl_d = mem_ctrl_q;
        mem_dst_d  = mem_dst_q;
        wb_ctrl_d  = wb_ctrl_q;
        wb_dst_d   = wb_dst_q;
        illegal_d  = 1'b0;
        if (!mem_busy_i) begin
            mem_ctrl_d = ex_ctrl_q;
            mem_dst_d  = ex_dst_q;
            wb_ctrl_d  = mem_ctrl_q;
            wb_dst_d   = mem_dst_q;
            ex_ctrl_d  = BUBBLE;
            ex_dst_d   = '0;
            ex_rs_d    = '0;
            ex_rt_d    = '0;
            if (id_valid_i && !ex_flush_i && !load_use_c) begin
                if (dec_illegal) begin
                    illegal_d = 1'b1;
                end else begin
                    ex_ctrl_d = ctrl_t'(dec_ctrl);
                    ex_dst_d  = dec_dst;
                    ex_rs_d   = id_rs_i;
                    ex_rt_d   = id_rt_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q  <= BUBBLE;
            ex_dst_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            mem_ctrl_q <= BUBBLE;
            mem_dst_q  <= '0;
            wb_ctrl_q  <= BUBBLE;
            wb_dst_q   <= '0;
            illegal_q  <= 1'b0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_dst_q   <= ex_dst_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            mem_ctrl_q <= mem_ctrl_d;
            mem_dst_q  <= mem_dst_d;
            wb_ctrl_q  <= wb_ctrl_d;
            wb_dst_q   <= wb_dst_d;
            illegal_q  <= illegal_d;
        end
    end

    // EX/MEM result is newer than MEM/WB, so it wins; $0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic m_wr, input logic [REG_AW-1:0] m_dst,
                                           input logic w_wr, input logic [REG_AW-1:0] w_dst,
                                           input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (m_wr && (m_dst == src)) begin
                sel = 2'b10;
            end else if (w_wr && (w_dst == src)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    assign fwd_a_o = fwd_sel(mem_ctrl_q.reg_write, mem_dst_q, wb_ctrl_q.reg_write, wb_dst_q, ex_rs_q);
    assign fwd_b_o = fwd_sel(mem_ctrl_q.reg_write, mem_dst_q, wb_ctrl_q.reg_write, wb_dst_q, ex_rt_q);

    assign ex_ctrl_o    = ex_ctrl_q;
    assign ex_dst_o     = ex_dst_q;
    assign mem_ctrl_o   = mem_ctrl_q;
    assign mem_dst_o    = mem_dst_q;
    assign wb_ctrl_o    = wb_ctrl_q;
    assign wb_dst_o     = wb_dst_q;
    assign illegal_op_o = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: a reference pipeline model pushes the
// expected post-edge state each cycle; it is popped and compared after the edge.
module tb_pipe_ctrl_unit;
    import pipe_ctrl_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [5:0] id_op = '0, id_funct = '0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       ex_flush = 1'b0, mem_busy = 1'b0;
    logic       hazard_stall, illegal_op;
    ctrl_t      ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0] ex_dst, mem_dst, wb_dst;
    logic [1:0] fwd_a, fwd_b;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_AW(5), .JUMP_EN(1), .LINK_REG(31)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid),
        .id_op_i        (id_op),
        .id_funct_i     (id_funct),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_rd_i        (id_rd),
        .ex_flush_i     (ex_flush),
        .mem_busy_i     (mem_busy),
        .hazard_stall_o (hazard_stall),
        .illegal_op_o   (illegal_op),
        .ex_ctrl_o      (ex_ctrl),
        .ex_dst_o       (ex_dst),
        .mem_ctrl_o     (mem_ctrl),
        .mem_dst_o      (mem_dst),
        .wb_ctrl_o      (wb_ctrl),
        .wb_dst_o       (wb_dst),
        .fwd_a_o        (fwd_a),
        .fwd_b_o        (fwd_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed { ctrl_t c; logic [4:0] dst; logic ill; logic rrt; } dec_t;
    typedef struct packed { ctrl_t c; logic [4:0] dst; logic [4:0] rs; logic [4:0] rt; } stg_t;
    typedef struct packed {
        ctrl_t exc; logic [4:0] exd; ctrl_t mc; logic [4:0] md; ctrl_t wc; logic [4:0] wd;
        logic ill; logic [1:0] fa; logic [1:0] fb;
    } sb_t;

    stg_t m_ex = '0, m_mem = '0, m_wb = '0;
    logic m_ill = 1'b0;
    sb_t  sbq[$];

    function automatic ctrl_t imm_op(input logic [3:0] alu);
        ctrl_t c;
        c = '0;
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.alu_ctrl  = alu;
        return c;
    endfunction

    // Reference decode from the instruction-set table, using raw encodings.
    function automatic dec_t ref_dec(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] rt, input logic [4:0] rd);
        dec_t d;
        d = '0;
        if (op == 6'h00) begin
            d.c.reg_write = 1'b1;
            d.dst = rd;
            d.rrt = 1'b1;
            case (fn)
                6'h20, 6'h21: d.c.alu_ctrl = 4'b0010;
                6'h22, 6'h23: d.c.alu_ctrl = 4'b0110;
                6'h24: d.c.alu_ctrl = 4'b0000;
                6'h25: d.c.alu_ctrl = 4'b0001;
                6'h26: d.c.alu_ctrl = 4'b0011;
                6'h27: d.c.alu_ctrl = 4'b1100;
                6'h2A: d.c.alu_ctrl = 4'b0111;
                6'h04: d.c.alu_ctrl = 4'b0100;
                6'h06: d.c.alu_ctrl = 4'b0101;
                6'h07: d.c.alu_ctrl = 4'b1000;
                6'h00: begin d.c.alu_ctrl = 4'b0100; d.c.alu_src_shamt = 1'b1; end
                6'h02: begin d.c.alu_ctrl = 4'b0101; d.c.alu_src_shamt = 1'b1; end
                6'h03: begin d.c.alu_ctrl = 4'b1000; d.c.alu_src_shamt = 1'b1; end
                6'h08: begin d = '0; d.c.jump_reg = 1'b1; end
                default: d.ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09: begin d.c = imm_op(4'b0010); d.dst = rt; end
                6'h0C: begin d.c = imm_op(4'b0000); d.dst = rt; end
                6'h0D: begin d.c = imm_op(4'b0001); d.dst = rt; end
                6'h0E: begin d.c = imm_op(4'b0011); d.dst = rt; end
                6'h23: begin d.c = imm_op(4'b0010); d.c.mem_to_reg = 1'b1; d.dst = rt; end
                6'h2B: begin d.c.mem_write = 1'b1; d.c.alu_src = 1'b1; d.c.alu_ctrl = 4'b0010; d.rrt = 1'b1; end
                6'h04: begin d.c.branch = 1'b1; d.c.alu_ctrl = 4'b1001; d.rrt = 1'b1; end
                6'h05: begin d.c.branch = 1'b1; d.c.alu_ctrl = 4'b1010; d.rrt = 1'b1; end
                6'h02: d.c.jump = 1'b1;
                6'h03: begin d.c.jump = 1'b1; d.c.link = 1'b1; d.c.reg_write = 1'b1; d.dst = 5'd31; end
                default: d.ill = 1'b1;
            endcase
        end
        if (d.ill) begin
            d = '0;
            d.ill = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [1:0] ref_fwd(input stg_t mm, input stg_t ww, input logic [4:0] src);
        if (src != 5'd0 && mm.c.reg_write && mm.dst == src) return 2'b10;
        if (src != 5'd0 && ww.c.reg_write && ww.dst == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic reset_model();
        m_ex = '0;
        m_mem = '0;
        m_wb = '0;
        m_ill = 1'b0;
        sbq.delete();
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_ex_ctrl"}, 32'(ex_ctrl), 32'd0);
        chk({pfx, "_ex_dst"}, 32'(ex_dst), 32'd0);
        chk({pfx, "_mem_ctrl"}, 32'(mem_ctrl), 32'd0);
        chk({pfx, "_wb_ctrl"}, 32'(wb_ctrl), 32'd0);
        chk({pfx, "_wb_dst"}, 32'(wb_dst), 32'd0);
        chk({pfx, "_illegal"}, 32'(illegal_op), 32'd0);
        chk({pfx, "_fwd"}, 32'({fwd_a, fwd_b}), 32'd0);
        chk({pfx, "_stall"}, 32'(hazard_stall), 32'd0);
    endtask

    // One clock: drive at negedge, check stall, predict, then compare after the edge.
    task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic fl, input logic bz, output logic st);
        dec_t d;
        logic stall;
        sb_t  e, g;
        @(negedge clk);
        id_valid = v; id_op = op; id_funct = fn;
        id_rs = rs; id_rt = rt; id_rd = rd;
        ex_flush = fl; mem_busy = bz;
        d = ref_dec(op, fn, rt, rd);
        stall = v && m_ex.c.mem_to_reg && (m_ex.dst != 5'd0) &&
                ((m_ex.dst == rs) || (d.rrt && m_ex.dst == rt)) && !fl;
        #1;
        st = hazard_stall;
        chk("hazard_stall", 32'(hazard_stall), 32'(stall));
        if (bz) begin
            m_ill = 1'b0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ill = v && d.ill && !fl && !stall;
            m_ex  = '0;
            if (v && !fl && !stall && !d.ill) begin
                m_ex.c = d.c; m_ex.dst = d.dst; m_ex.rs = rs; m_ex.rt = rt;
            end
        end
        e.exc = m_ex.c;  e.exd = m_ex.dst;
        e.mc  = m_mem.c; e.md  = m_mem.dst;
        e.wc  = m_wb.c;  e.wd  = m_wb.dst;
        e.ill = m_ill;
        e.fa  = ref_fwd(m_mem, m_wb, m_ex.rs);
        e.fb  = ref_fwd(m_mem, m_wb, m_ex.rt);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            g = sbq.pop_front();
            chk("ex_ctrl", 32'(ex_ctrl), 32'(g.exc));
            chk("ex_dst", 32'(ex_dst), 32'(g.exd));
            chk("mem_ctrl", 32'(mem_ctrl), 32'(g.mc));
            chk("mem_dst", 32'(mem_dst), 32'(g.md));
            chk("wb_ctrl", 32'(wb_ctrl), 32'(g.wc));
            chk("wb_dst", 32'(wb_dst), 32'(g.wd));
            chk("illegal_op", 32'(illegal_op), 32'(g.ill));
            chk("fwd_a", 32'(fwd_a), 32'(g.fa));
            chk("fwd_b", 32'(fwd_b), 32'(g.fb));
        end
    endtask

    task automatic idle(input int n);
        logic s;
        for (int k = 0; k < n; k++) step(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, s);
    endtask

    logic [11:0] op_tab [0:29];

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic st;
        logic [11:0] sel;
        op_tab = '{12'h020, 12'h021, 12'h022, 12'h023, 12'h024, 12'h025, 12'h026, 12'h027,
                   12'h02A, 12'h000, 12'h002, 12'h003, 12'h004, 12'h006, 12'h007, 12'h008,
                   12'h200, 12'h240, 12'h300, 12'h340, 12'h380, 12'h100, 12'h140, 12'h8C0,
                   12'h8C0, 12'hAC0, 12'h080, 12'h0C0, 12'hFC0, 12'h03F};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        idle(10);
        check_zero("idle");

        // add $3,$1,$2
        step(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, st);
        chk("add_alu", 32'(ex_ctrl.alu_ctrl), 32'h2);
        chk("add_reg_write", 32'(ex_ctrl.reg_write), 32'd1);
        idle(2);
        chk("add_wb_dst", 32'(wb_dst), 32'd3);

        // lw $5,0($1); add $6,$5,$2 -> one stall, then MEM/WB forward
        step(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0, st);
        step(1'b1, 6'h00, 6'h20, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, st);
        chk("lu_stall", 32'(st), 32'd1);
        chk("lu_bubble", 32'(ex_ctrl), 32'd0);
        step(1'b1, 6'h00, 6'h20, 5'd5, 5'd2, 5'd6, 1'b0, 1'b0, st);
        chk("lu_release", 32'(st), 32'd0);
        chk("lu_fwd_a", 32'(fwd_a), 32'h1);
        idle(3);

        // load-use pair killed by ex_flush
        step(1'b1, 6'h23, 6'h00, 5'd1, 5'd7, 5'd0, 1'b0, 1'b0, st);
        step(1'b1, 6'h00, 6'h20, 5'd7, 5'd2, 5'd8, 1'b1, 1'b0, st);
        chk("fl_stall", 32'(st), 32'd0);
        chk("fl_bubble", 32'(ex_ctrl), 32'd0);
        chk("fl_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        idle(3);

        // stream with a 3-cycle mem_busy freeze
        step(1'b1, 6'h08, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, st);
        step(1'b1, 6'h00, 6'h22, 5'd8, 5'd2, 5'd9, 1'b0, 1'b0, st);
        chk("sub_fwd_a_exmem", 32'(fwd_a), 32'h2);
        step(1'b1, 6'h00, 6'h25, 5'd9, 5'd8, 5'd10, 1'b0, 1'b0, st);
        for (int k = 0; k < 3; k++) step(1'b1, 6'h00, 6'h26, 5'd10, 5'd9, 5'd11, 1'b0, 1'b1, st);
        chk("busy_ex_dst", 32'(ex_dst), 32'd10);
        chk("busy_wb_dst", 32'(wb_dst), 32'd8);
        step(1'b1, 6'h00, 6'h26, 5'd10, 5'd9, 5'd11, 1'b0, 1'b0, st);
        idle(3);

        // illegal opcode 0x3F
        step(1'b1, 6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, st);
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        chk("ill_bubble", 32'(ex_ctrl), 32'd0);
        idle(1);
        chk("ill_clear", 32'(illegal_op), 32'd0);

        // jal
        step(1'b1, 6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, st);
        idle(2);
        chk("jal_wb_dst", 32'(wb_dst), 32'd31);
        chk("jal_link", 32'(wb_ctrl.link), 32'd1);

        // random stream with an asynchronous reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                id_valid = 1'b0;
                #1;
                check_zero("arst");
                reset_model();
                @(negedge clk);
                rst_n = 1'b1;
            end
            sel = op_tab[$urandom_range(29, 0)];
            step($urandom_range(99, 0) < 85, sel[11:6], sel[5:0],
                 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                 $urandom_range(99, 0) < 10, $urandom_range(99, 0) < 10, st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
